// File: rtl/dp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dp_pkg : mode encodings and FSM state type for dot_product_engine
// Rev 1.0
// ---------------------------------------------------------------------------
package dp_pkg;

  localparam logic [1:0] MODE_DOT   = 2'd0;
  localparam logic [1:0] MODE_SUMSQ = 2'd1;
  localparam logic [1:0] MODE_SUM   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_MAC  = 3'd3,
    ST_SAT  = 3'd4,
    ST_WB   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dp_saturate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dp_saturate : clamps a full-precision accumulator to RES_W bits, flags ovf
// Rev 1.0
// ---------------------------------------------------------------------------
module dp_saturate
  import dp_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int RES_W = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic             i_signed,
  output logic [RES_W-1:0] o_result,
  output logic             o_ovf
);

  localparam logic signed [ACC_W-1:0] U_MAX = {{(ACC_W-RES_W){1'b0}}, {RES_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

  logic signed [ACC_W-1:0] w_acc;
  assign w_acc = $signed(i_acc);

  always_comb begin
    o_result = i_acc[RES_W-1:0];
    o_ovf    = 1'b0;
    if (i_signed) begin
      if (w_acc > S_MAX) begin
        o_result = S_MAX[RES_W-1:0];
        o_ovf    = 1'b1;
      end else if (w_acc < S_MIN) begin
        o_result = S_MIN[RES_W-1:0];
        o_ovf    = 1'b1;
      end
    end else begin
      // Negative sums cannot arise from zero-extended operands, clamp anyway.
      if (w_acc[ACC_W-1]) begin
        o_result = '0;
        o_ovf    = 1'b1;
      end else if (w_acc > U_MAX) begin
        o_result = U_MAX[RES_W-1:0];
        o_ovf    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dot_product_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dot_product_engine : DOT / SUMSQ / SUM over memory vectors, saturating result
// Rev 1.0
// ---------------------------------------------------------------------------
module dot_product_engine
  import dp_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int MAX_LEN = 8,
  parameter int RES_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int ACC_W  = 2 * DATA_W + $clog2(MAX_LEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              signed_mode,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [RES_W-1:0]  result,
  output logic [ACC_W-1:0]  acc
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d, len_q, len_d;
  logic [1:0]         mode_q, mode_d;
  logic               sgn_q, sgn_d, wb_en_q, wb_en_d;
  logic [ADDR_W-1:0]  base_a_q, base_a_d, base_b_q, base_b_d, wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [ACC_W-1:0]   sum_q, sum_d, acc_q, acc_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               err_q, err_d, ovf_q, ovf_d, done_q, done_d, busy_q, busy_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;

  logic signed [ACC_W-1:0] w_op_a, w_op_b, w_term;
  logic [RES_W-1:0]        w_sat_res;
  logic                    w_sat_ovf, w_reject, w_last;

  function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] x, input logic s);
    ext = s ? {{(ACC_W-DATA_W){x[DATA_W-1]}}, x} : {{(ACC_W-DATA_W){1'b0}}, x};
  endfunction

  dp_saturate #(.ACC_W(ACC_W), .RES_W(RES_W)) u_sat (
    .i_acc    (sum_q),
    .i_signed (sgn_q),
    .o_result (w_sat_res),
    .o_ovf    (w_sat_ovf)
  );

  assign w_reject = (len == '0) || (len > LEN_W'(MAX_LEN)) || (mode == 2'd3);
  assign w_last   = (idx_q == len_q - 1'b1);

  always_comb begin
    w_op_a = ext(mem_data_in, sgn_q);
    w_op_b = ext(mem_data_in, sgn_q);
    if (mode_q == MODE_DOT) w_op_a = ext(a_q, sgn_q);
    w_term = (mode_q == MODE_SUM) ? w_op_b : w_op_a * w_op_b;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    mode_d    = mode_q;
    sgn_d     = sgn_q;
    wb_en_d   = wb_en_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    wb_addr_d = wb_addr_q;
    a_d       = a_q;
    sum_d     = sum_q;
    acc_d     = acc_q;
    result_d  = result_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: if (start) begin
        len_d     = len;
        mode_d    = mode;
        sgn_d     = signed_mode;
        wb_en_d   = wb_en;
        base_a_d  = base_a;
        base_b_d  = base_b;
        wb_addr_d = wb_addr;
        idx_d     = '0;
        sum_d     = '0;
        acc_d     = '0;
        result_d  = '0;
        if (w_reject) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: state_d = (mode_q == MODE_DOT) ? ST_RD_B : ST_MAC;
      ST_RD_B: begin
        a_d     = mem_data_in;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        sum_d = sum_q + w_term;
        if (w_last) begin
          state_d = ST_SAT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD_A;
        end
      end
      ST_SAT: begin
        result_d = w_sat_res;
        acc_d    = sum_q;
        if (wb_en_q) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          ovf_d   = w_sat_ovf;
        end
      end
      ST_WB: begin
        state_d = ST_DONE;
        err_d   = 1'b0;
        ovf_d   = w_sat_ovf;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Memory-side outputs are registered from the next state so they line up with it.
    mem_addr_d = '0;
    case (state_d)
      ST_RD_A: mem_addr_d = base_a_d + ADDR_W'(idx_d);
      ST_RD_B: mem_addr_d = base_b_d + ADDR_W'(idx_d);
      ST_WB:   mem_addr_d = wb_addr_d;
      default: mem_addr_d = '0;
    endcase
    mem_wr_d = (state_d == ST_WB);
    done_d   = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      mode_q     <= '0;
      sgn_q      <= 1'b0;
      wb_en_q    <= 1'b0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      wb_addr_q  <= '0;
      a_q        <= '0;
      sum_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      sgn_q      <= sgn_d;
      wb_en_q    <= wb_en_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      wb_addr_q  <= wb_addr_d;
      a_q        <= a_d;
      sum_q      <= sum_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  generate
    if (DATA_W == RES_W) begin : g_wd_eq
      assign mem_data_out = result_q;
    end else if (DATA_W > RES_W) begin : g_wd_ext
      assign mem_data_out = {{(DATA_W-RES_W){sgn_q & result_q[RES_W-1]}}, result_q};
    end else begin : g_wd_trunc
      assign mem_data_out = result_q[DATA_W-1:0];
    end
  endgenerate

  assign mem_addr = mem_addr_q;
  assign mem_wr   = mem_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ovf      = ovf_q;
  assign result   = result_q;
  assign acc      = acc_q;

endmodule
`default_nettype wire
